// File: rtl/ura_register_bank_if.sv
// URA register-bank access bus: two combinational read ports and one write port.
// The master (decode/write-back side) drives URAs and write data; the bank answers reads.
interface ura_register_bank_if;
  logic [6:0]  ra_ura;
  logic [6:0]  rb_ura;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic        ra_invalid;
  logic        rb_invalid;
  logic        we;
  logic [6:0]  w_ura;
  logic [31:0] w_data;

  modport master (
    output ra_ura, rb_ura, we, w_ura, w_data,
    input  ra_data, rb_data, ra_invalid, rb_invalid
  );

  modport slave (
    input  ra_ura, rb_ura, we, w_ura, w_data,
    output ra_data, rb_data, ra_invalid, rb_invalid
  );
endinterface

// File: rtl/ura_register_bank.sv
// URA-addressed storage for GRF, CP0 SR/Cause/EPC/PRId and HI/LO, plus exception
// entry/return bookkeeping (EXL, EPC capture, Cause update) and interrupt request.
module ura_register_bank #(
  parameter logic [31:0] PRID   = 32'h2020_0052,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  ura_register_bank_if.slave         bus,
  input  logic [5:0]                 hw_int,
  input  logic                       exc_enter,
  input  logic [4:0]                 exc_code,
  input  logic                       exc_bd,
  input  logic [31:0]                exc_epc,
  input  logic                       eret,
  output logic                       int_req,
  output logic [31:0]                epc_out,
  output logic                       exl_out
);

  localparam logic [1:0] GrpGrf  = 2'b00;
  localparam logic [1:0] GrpCp0  = 2'b01;
  localparam logic [1:0] GrpMul  = 2'b10;

  localparam logic [4:0] Cp0Sr    = 5'd12;
  localparam logic [4:0] Cp0Cause = 5'd13;
  localparam logic [4:0] Cp0Epc   = 5'd14;
  localparam logic [4:0] Cp0Prid  = 5'd15;

  typedef struct packed {
    logic        invalid;
    logic [31:0] data;
  } rd_t;

  // Architectural state
  logic [31:0] grf_q [32];
  logic [31:0] hi_q, lo_q;
  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic grf_we, hi_we, lo_we, sr_we, epc_we;
  logic [31:0] sr_val, cause_val;
  rd_t rd_a, rd_b;

  assign sr_val    = {16'h0, sr_im_q, 8'h0, sr_exl_q, sr_ie_q};
  assign cause_val = {cause_bd_q, 15'h0, cause_ip_q, 3'h0, cause_exc_q, 2'b00};

  // Write decode; anything not listed (GRF 0, Cause, PRId, invalid URAs) is dropped.
  always_comb begin
    grf_we = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    sr_we  = 1'b0;
    epc_we = 1'b0;
    if (bus.we) begin
      unique case (bus.w_ura[6:5])
        GrpGrf: grf_we = (bus.w_ura[4:0] != 5'd0);
        GrpCp0: begin
          sr_we  = (bus.w_ura[4:0] == Cp0Sr);
          epc_we = (bus.w_ura[4:0] == Cp0Epc);
        end
        GrpMul: begin
          hi_we = (bus.w_ura[4:0] == 5'd0);
          lo_we = (bus.w_ura[4:0] == 5'd1);
        end
        default: ;
      endcase
    end
  end

  function automatic logic bypassable(input logic [6:0] ura);
    return ((ura[6:5] == GrpGrf) && (ura[4:0] != 5'd0)) ||
           ((ura[6:5] == GrpMul) && (ura[4:1] == 4'd0));
  endfunction

  function automatic rd_t read_ura(input logic [6:0] ura);
    rd_t r;
    r.invalid = 1'b0;
    r.data    = 32'h0;
    unique case (ura[6:5])
      GrpGrf: begin
        if (ura[4:0] != 5'd0) r.data = grf_q[ura[4:0]];
      end
      GrpCp0: begin
        case (ura[4:0])
          Cp0Sr:    r.data = sr_val;
          Cp0Cause: r.data = cause_val;
          Cp0Epc:   r.data = epc_q;
          Cp0Prid:  r.data = PRID;
          default:  r.invalid = 1'b1;
        endcase
      end
      GrpMul: begin
        case (ura[4:0])
          5'd0:    r.data = hi_q;
          5'd1:    r.data = lo_q;
          default: r.invalid = 1'b1;
        endcase
      end
      default: r.invalid = 1'b1;
    endcase
    // CP0 is excluded from forwarding so exception state is always seen as registered.
    if (BYPASS && bus.we && (ura == bus.w_ura) && bypassable(ura)) r.data = bus.w_data;
    return r;
  endfunction

  always_comb begin
    rd_a = read_ura(bus.ra_ura);
    rd_b = read_ura(bus.rb_ura);
  end

  assign bus.ra_data    = rd_a.data;
  assign bus.ra_invalid = rd_a.invalid;
  assign bus.rb_data    = rd_b.data;
  assign bus.rb_invalid = rd_b.invalid;

  // Priority on EXL: exception entry > eret > software write.
  always_comb begin
    sr_im_d  = sr_im_q;
    sr_ie_d  = sr_ie_q;
    sr_exl_d = sr_exl_q;
    if (sr_we && !exc_enter) begin
      sr_im_d  = bus.w_data[15:10];
      sr_ie_d  = bus.w_data[0];
      sr_exl_d = bus.w_data[1];
    end
    if (eret)      sr_exl_d = 1'b0;
    if (exc_enter) sr_exl_d = 1'b1;
  end

  always_comb begin
    epc_d       = epc_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    cause_ip_d  = hw_int;
    if (epc_we) epc_d = bus.w_data;
    if (exc_enter) begin
      epc_d       = exc_epc;
      cause_bd_d  = exc_bd;
      cause_exc_d = exc_code;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_ie_q     <= 1'b0;
      sr_exl_q    <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_ie_q     <= sr_ie_d;
      sr_exl_q    <= sr_exl_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= bus.w_data;
      if (lo_we) lo_q <= bus.w_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
    end else if (grf_we) begin
      grf_q[bus.w_ura[4:0]] <= bus.w_data;
    end
  end

  assign int_req = sr_ie_q & ~sr_exl_q & |(cause_ip_q & sr_im_q);
  assign epc_out = epc_q;
  assign exl_out = sr_exl_q;

endmodule

// File: tb/tb_ura_register_bank.sv
// Directed bench for ura_register_bank: vector table for read/write/bypass/decode,
// hand-written sequences for CP0, exception, eret and asynchronous reset behaviour.
module tb_ura_register_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic        exc_enter;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic        eret;
  logic        int_req;
  logic [31:0] epc_out;
  logic        exl_out;

  int checks = 0;
  int failures = 0;

  ura_register_bank_if bus ();

  ura_register_bank dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .hw_int    (hw_int),
    .exc_enter (exc_enter),
    .exc_code  (exc_code),
    .exc_bd    (exc_bd),
    .exc_epc   (exc_epc),
    .eret      (eret),
    .int_req   (int_req),
    .epc_out   (epc_out),
    .exl_out   (exl_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [6:0]  w_ura;
    logic [31:0] w_data;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [31:0] exp_ra;
    logic        exp_ra_inv;
    logic [31:0] exp_rb;
    logic        exp_rb_inv;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.we     = 1'b0;
    bus.w_ura  = 7'h0;
    bus.w_data = 32'h0;
    exc_enter  = 1'b0;
    eret       = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    hw_int    = 6'h0;
    exc_code  = 5'h0;
    exc_bd    = 1'b0;
    exc_epc   = 32'h0;
    bus.ra_ura = 7'h0;
    bus.rb_ura = 7'h0;
    idle_bus();

    vecs[0]  = '{1'b1, 7'h05, 32'hDEAD_BEEF, 7'h05, 7'h00, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 7'h00, 32'hFFFF_FFFF, 7'h00, 7'h05, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 7'h00, 32'h0, 7'h00, 7'h05, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 7'h41, 32'h0000_1111, 7'h41, 7'h40, 32'h0000_1111, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 7'h00, 32'h0, 7'h40, 7'h41, 32'h0, 1'b0, 32'h0000_1111, 1'b0};
    vecs[5]  = '{1'b0, 7'h00, 32'h0, 7'h60, 7'h20, 32'h0, 1'b1, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 7'h60, 32'h0000_0055, 7'h60, 7'h42, 32'h0, 1'b1, 32'h0, 1'b1};
    vecs[7]  = '{1'b1, 7'h2F, 32'h0, 7'h2F, 7'h2B, 32'h2020_0052, 1'b0, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 7'h40, 32'hA5A5_0000, 7'h40, 7'h1F, 32'hA5A5_0000, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 7'h1F, 32'h0000_00FF, 7'h1F, 7'h41, 32'h0000_00FF, 1'b0, 32'h0000_1111, 1'b0};
    vecs[10] = '{1'b1, 7'h2D, 32'hFFFF_FFFF, 7'h2D, 7'h2E, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 7'h00, 32'h0, 7'h2D, 7'h40, 32'h0, 1'b0, 32'hA5A5_0000, 1'b0};
    vecs[12] = '{1'b1, 7'h2E, 32'h0000_BEE0, 7'h2E, 7'h2C, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 7'h00, 32'h0, 7'h2E, 7'h1F, 32'h0000_BEE0, 1'b0, 32'h0000_00FF, 1'b0};

    step();
    step();
    check("rst_int_req", {31'h0, int_req}, 32'h0);
    check("rst_exl", {31'h0, exl_out}, 32'h0);
    check("rst_epc", epc_out, 32'h0);
    reset = 1'b1;
    step();

    // Full URA sweep after reset: valid URAs read 0 except PRId.
    for (int u = 0; u < 128; u++) begin
      logic [6:0] ura;
      logic       exp_inv;
      logic [31:0] exp_d;
      ura = u[6:0];
      exp_inv = !((ura[6:5] == 2'b00) ||
                  (ura[6:5] == 2'b01 && ura[4:0] >= 5'd12 && ura[4:0] <= 5'd15) ||
                  (ura[6:5] == 2'b10 && ura[4:0] <= 5'd1));
      exp_d = (ura == 7'h2F) ? 32'h2020_0052 : 32'h0;
      bus.ra_ura = ura;
      #1;
      check($sformatf("sweep_data_%02h", ura), bus.ra_data, exp_d);
      check($sformatf("sweep_inv_%02h", ura), {31'h0, bus.ra_invalid}, {31'h0, exp_inv});
    end
    check("sweep_int_req", {31'h0, int_req}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      bus.we     = vecs[i].we;
      bus.w_ura  = vecs[i].w_ura;
      bus.w_data = vecs[i].w_data;
      bus.ra_ura = vecs[i].ra;
      bus.rb_ura = vecs[i].rb;
      #1;
      check($sformatf("vec%0d_ra", i), bus.ra_data, vecs[i].exp_ra);
      check($sformatf("vec%0d_ra_inv", i), {31'h0, bus.ra_invalid}, {31'h0, vecs[i].exp_ra_inv});
      check($sformatf("vec%0d_rb", i), bus.rb_data, vecs[i].exp_rb);
      check($sformatf("vec%0d_rb_inv", i), {31'h0, bus.rb_invalid}, {31'h0, vecs[i].exp_rb_inv});
      step();
    end
    idle_bus();

    // SR masking and EXL gating of interrupts.
    bus.ra_ura = 7'h2C;
    bus.rb_ura = 7'h2D;
    bus.we = 1'b1; bus.w_ura = 7'h2C; bus.w_data = 32'hFFFF_FFFF;
    step();
    idle_bus();
    #1;
    check("sr_masked", bus.ra_data, 32'h0000_FC03);
    check("sr_exl_set", {31'h0, exl_out}, 32'h1);
    hw_int = 6'h3F;
    step();
    check("cause_ip", bus.rb_data, 32'h0000_FC00);
    check("int_blocked_by_exl", {31'h0, int_req}, 32'h0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("eret_clears_exl", {31'h0, exl_out}, 32'h0);
    check("int_req_after_eret", {31'h0, int_req}, 32'h1);

    // Software SR write racing eret: eret owns EXL, other bits follow the write.
    bus.we = 1'b1; bus.w_ura = 7'h2C; bus.w_data = 32'h0000_0402; eret = 1'b1;
    step();
    idle_bus();
    #1;
    check("sr_write_vs_eret", bus.ra_data, 32'h0000_0400);
    check("int_req_ie_off", {31'h0, int_req}, 32'h0);

    // Exception entry overriding a same-cycle EPC write.
    bus.ra_ura = 7'h2E;
    bus.we = 1'b1; bus.w_ura = 7'h2E; bus.w_data = 32'h0000_1234;
    exc_enter = 1'b1; exc_code = 5'd4; exc_bd = 1'b1; exc_epc = 32'h0000_3004;
    step();
    idle_bus();
    #1;
    check("exc_epc_read", bus.ra_data, 32'h0000_3004);
    check("exc_epc_out", epc_out, 32'h0000_3004);
    check("exc_cause", bus.rb_data, 32'h8000_FC10);
    check("exc_exl", {31'h0, exl_out}, 32'h1);

    // Exception and eret in the same cycle, then eret alone.
    eret = 1'b1; exc_enter = 1'b1;
    step();
    exc_enter = 1'b0;
    check("exc_beats_eret", {31'h0, exl_out}, 32'h1);
    step();
    eret = 1'b0;
    check("eret_alone", {31'h0, exl_out}, 32'h0);

    // Asynchronous reset mid-stream with a pending write.
    bus.ra_ura = 7'h05;
    bus.rb_ura = 7'h41;
    bus.we = 1'b1; bus.w_ura = 7'h05; bus.w_data = 32'h0000_0001;
    #2;
    reset = 1'b0;
    #1;
    check("arst_grf5", bus.ra_data, 32'h0000_0001);  // bypass of the live write still visible
    check("arst_lo", bus.rb_data, 32'h0);
    check("arst_epc", epc_out, 32'h0);
    check("arst_int_req", {31'h0, int_req}, 32'h0);
    bus.rb_ura = 7'h2F;
    #1;
    check("arst_prid", bus.rb_data, 32'h2020_0052);
    step();
    idle_bus();
    #1;
    check("arst_write_aborted", bus.ra_data, 32'h0);
    reset = 1'b1;
    step();
    bus.ra_ura = 7'h40;
    bus.rb_ura = 7'h1F;
    #1;
    check("post_rst_hi", bus.ra_data, 32'h0);
    check("post_rst_grf31", bus.rb_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
